// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus word-level TX/RX handshake for spi_slave
// Signals:
//   spi_clk_i, spi_ss_n_i, spi_mosi_i, spi_miso_o          mode-0 SPI bus
//   tx_data_i, tx_bytes_valid_i, tx_load_i, tx_ready_o     transmit word buffer
//   rx_data_o, rx_bytes_valid_o, rx_word_valid_o, rx_ack_i receive word
//   overrun_o                                              only with SPI_SLAVE_OVERRUN_EN
interface spi_slave_if;
  logic        spi_clk_i;
  logic        spi_ss_n_i;
  logic        spi_mosi_i;
  logic        spi_miso_o;
  logic [31:0] tx_data_i;
  logic [2:0]  tx_bytes_valid_i;
  logic        tx_load_i;
  logic        tx_ready_o;
  logic [31:0] rx_data_o;
  logic [2:0]  rx_bytes_valid_o;
  logic        rx_word_valid_o;
  logic        rx_ack_i;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic        overrun_o;
`endif
  modport slave(
    input  spi_clk_i, spi_ss_n_i, spi_mosi_i, tx_data_i, tx_bytes_valid_i, tx_load_i, rx_ack_i,
`ifdef SPI_SLAVE_OVERRUN_EN
    output overrun_o,
`endif
    output spi_miso_o, tx_ready_o, rx_data_o, rx_bytes_valid_o, rx_word_valid_o
  );
  modport master(
    output spi_clk_i, spi_ss_n_i, spi_mosi_i, tx_data_i, tx_bytes_valid_i, tx_load_i, rx_ack_i,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  overrun_o,
`endif
    input  spi_miso_o, tx_ready_o, rx_data_o, rx_bytes_valid_o, rx_word_valid_o
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave assembling up to 4-byte words in both directions
// Ports: clk_i system clock, rst_i sync active-high reset, bus spi_slave_if.slave
// Parameter SYNC_STAGES (2..3): synchroniser depth on spi_clk_i/spi_ss_n_i/spi_mosi_i
// Macro SPI_SLAVE_OVERRUN_EN: adds sticky overrun_o and keeps the old word on overrun
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic       clk_i,
  input logic       rst_i,
  spi_slave_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic sck_d, ss_d;
  logic [7:0] rx_sr, tx_sr, rx_byte;
  logic [2:0] bit_cnt, byte_cnt, tx_left, tx_clamp;
  logic [31:0] word, tx_buf, rx_data;
  logic [2:0] rx_bytes;
  logic rx_valid, tx_ready;
  logic sck_s, ss_s, mosi_s, sck_rise, sck_fall, ss_rise, ss_fall, active;
  logic pub, ovr, take, load_pt, shift_pt;
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;
  assign active   = state == ACTIVE;
  assign rx_byte  = {rx_sr[6:0], mosi_s};
  assign tx_clamp = bus.tx_bytes_valid_i > 3'd4 ? 3'd4 : bus.tx_bytes_valid_i;
  // The fall after the 8th rise sees bit_cnt wrapped to 0 and loads the next byte instead of shifting
  assign load_pt  = (~active & ss_fall) | (active & sck_fall & bit_cnt == 3'd0);
  assign shift_pt = active & sck_fall & bit_cnt != 3'd0;
  assign pub      = byte_cnt == 3'd4 | (active & ss_rise & byte_cnt != 3'd0);
  assign ovr      = pub & rx_valid & ~bus.rx_ack_i;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun;
  assign take = pub & ~ovr;
  assign bus.overrun_o = overrun;
  always_ff @(posedge clk_i)
    overrun <= rst_i ? 1'b0 : ovr | (overrun & ~bus.rx_ack_i);
`else
  assign take = pub;
`endif
  // Synchronisers reset to 0 so a transfer in flight at reset is ignored until a fresh ss fall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_clk_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_ss_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = active ? (ss_rise ? IDLE : ACTIVE) : (ss_fall ? ACTIVE : IDLE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || pub || ss_rise || ss_fall) begin
      rx_sr    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      word     <= '0;
    end else if (active && sck_rise) begin
      rx_sr   <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        word     <= {word[23:0], rx_byte};
        byte_cnt <= byte_cnt + 3'd1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data  <= '0;
      rx_bytes <= '0;
      rx_valid <= 1'b0;
    end else if (take) begin
      rx_data  <= word;
      rx_bytes <= byte_cnt;
      rx_valid <= 1'b1;
    end else if (bus.rx_ack_i) begin
      rx_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_buf   <= '0;
      tx_left  <= '0;
      tx_ready <= 1'b1;
      tx_sr    <= '0;
    end else begin
      if (active && ss_rise) begin
        tx_left  <= '0;
        tx_ready <= 1'b1;
        tx_sr    <= '0;
      end else if (load_pt) begin
        tx_sr    <= tx_left != 3'd0 ? tx_buf[31:24] : 8'h00;
        tx_buf   <= tx_buf << 8;
        tx_left  <= tx_left != 3'd0 ? tx_left - 3'd1 : 3'd0;
        tx_ready <= tx_left <= 3'd1;
      end else if (shift_pt) begin
        tx_sr <= tx_sr << 1;
      end
      if (bus.tx_load_i && tx_ready) begin
        tx_buf   <= bus.tx_data_i;
        tx_left  <= tx_clamp;
        tx_ready <= 1'b0;
      end
    end
  end
  assign bus.spi_miso_o       = active & tx_sr[7];
  assign bus.tx_ready_o       = tx_ready;
  assign bus.rx_data_o        = rx_data;
  assign bus.rx_bytes_valid_o = rx_bytes;
  assign bus.rx_word_valid_o  = rx_valid;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench for spi_slave driving a mode-0 SPI master model
module tb_spi_slave;
  localparam int SS   = 2;
  localparam int HALF = 80;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_slave_if s();
  spi_slave #(.SYNC_STAGES(SS)) dut (.clk_i(clk), .rst_i(rst), .bus(s));
  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0]  miso_q[$];
  logic [34:0] rx_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tx_load(input logic [31:0] d, input logic [2:0] v, input bit accept);
    int n;
    @(negedge clk);
    s.tx_data_i        = d;
    s.tx_bytes_valid_i = v;
    s.tx_load_i        = 1'b1;
    @(negedge clk);
    s.tx_load_i = 1'b0;
    n = v > 4 ? 4 : int'(v);
    if (accept)
      for (int k = 0; k < n; k++) miso_q.push_back(d[31-8*k -: 8]);
  endtask
  task automatic push_rx(input logic [31:0] d, input int nbits);
    int nb;
    nb = nbits / 8;
    if (nb > 0) rx_q.push_back({3'(nb), d >> (32 - 8 * nb)});
  endtask
  task automatic ss_low();
    @(negedge clk);
    s.spi_ss_n_i = 1'b0;
    #(2 * HALF);
  endtask
  task automatic send_bits(input logic [31:0] d, input int n, input bit chk);
    logic [7:0] mb, exp;
    mb = '0;
    for (int i = 0; i < n; i++) begin
      s.spi_mosi_i = d[31-i];
      #HALF;
      mb = {mb[6:0], s.spi_miso_o};
      s.spi_clk_i = 1'b1;
      #HALF;
      s.spi_clk_i = 1'b0;
      if (chk && i % 8 == 7) begin
        exp = miso_q.size() > 0 ? miso_q.pop_front() : 8'h00;
        check("miso_byte", {24'h0, mb}, {24'h0, exp});
      end
    end
  endtask
  task automatic ss_high(input bit ack_pub);
    #HALF;
    @(negedge clk);
    s.spi_ss_n_i = 1'b1;
    if (ack_pub) begin
      repeat (SS) @(posedge clk);
      #1 s.rx_ack_i = 1'b1;
      @(posedge clk);
      #1 s.rx_ack_i = 1'b0;
    end
    repeat (10) @(negedge clk);
    miso_q.delete();
  endtask
  task automatic xfer(input logic [31:0] d, input int n, input bit ack_pub);
    ss_low();
    send_bits(d, n, 1'b1);
    ss_high(ack_pub);
  endtask
  task automatic rx_check(input string tag);
    logic [34:0] exp;
    for (int k = 0; k < 200 && s.rx_word_valid_o !== 1'b1; k++) @(negedge clk);
    check({tag, "_valid"}, {31'h0, s.rx_word_valid_o}, 32'h1);
    exp = rx_q.size() > 0 ? rx_q.pop_front() : '1;
    check({tag, "_data"}, s.rx_data_o, exp[31:0]);
    check({tag, "_bytes"}, {29'h0, s.rx_bytes_valid_o}, {29'h0, exp[34:32]});
  endtask
  task automatic ack_rx();
    @(negedge clk);
    s.rx_ack_i = 1'b1;
    @(negedge clk);
    s.rx_ack_i = 1'b0;
    check("ack_clears_valid", {31'h0, s.rx_word_valid_o}, 32'h0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("ack_clears_ovr", {31'h0, s.overrun_o}, 32'h0);
`endif
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    s.spi_clk_i = 1'b0;
    s.spi_ss_n_i = 1'b1;
    s.spi_mosi_i = 1'b0;
    s.tx_data_i = '0;
    s.tx_bytes_valid_i = '0;
    s.tx_load_i = 1'b0;
    s.rx_ack_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", {31'h0, s.tx_ready_o}, 32'h1);
    check("rst_rx_valid", {31'h0, s.rx_word_valid_o}, 32'h0);
    check("rst_rx_data", s.rx_data_o, 32'h0);
    check("rst_rx_bytes", {29'h0, s.rx_bytes_valid_o}, 32'h0);
    check("rst_miso", {31'h0, s.spi_miso_o}, 32'h0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("rst_overrun", {31'h0, s.overrun_o}, 32'h0);
`endif
    tx_load(32'hA1B2C3D4, 3'd4, 1'b1);
    check("load_busy", {31'h0, s.tx_ready_o}, 32'h0);
    tx_load(32'hFFFFFFFF, 3'd4, 1'b0);
    push_rx(32'h11223344, 32);
    xfer(32'h11223344, 32, 1'b0);
    check("tx_ready_after", {31'h0, s.tx_ready_o}, 32'h1);
    rx_check("word4");
    ack_rx();
    push_rx(32'hABCDF800, 21);
    xfer(32'hABCDF800, 21, 1'b0);
    rx_check("partial");
    ack_rx();
    tx_load(32'h5A123456, 3'd1, 1'b1);
    push_rx(32'h01020300, 24);
    ss_low();
    send_bits(32'h01020300, 24, 1'b1);
    check("tx_ready_1byte", {31'h0, s.tx_ready_o}, 32'h1);
    ss_high(1'b0);
    rx_check("three");
    ack_rx();
    tx_load(32'hCAFEF00D, 3'd7, 1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
    push_rx(32'h01020304, 32);
`else
    push_rx(32'h05060708, 32);
`endif
    xfer(32'h01020304, 32, 1'b0);
    xfer(32'h05060708, 32, 1'b0);
    rx_check("overrun");
`ifdef SPI_SLAVE_OVERRUN_EN
    check("overrun_flag", {31'h0, s.overrun_o}, 32'h1);
`endif
    ack_rx();
    xfer(32'h77000000, 8, 1'b0);
    check("pre_ack_valid", {31'h0, s.rx_word_valid_o}, 32'h1);
    push_rx(32'h99000000, 8);
    xfer(32'h99000000, 8, 1'b1);
    rx_check("ack_pub");
`ifdef SPI_SLAVE_OVERRUN_EN
    check("ack_pub_ovr", {31'h0, s.overrun_o}, 32'h0);
`endif
    ss_low();
    send_bits(32'hF0F0F0F0, 12, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rx_data", s.rx_data_o, 32'h0);
    check("mid_rst_valid", {31'h0, s.rx_word_valid_o}, 32'h0);
    check("mid_rst_bytes", {29'h0, s.rx_bytes_valid_o}, 32'h0);
    check("mid_rst_ready", {31'h0, s.tx_ready_o}, 32'h1);
    check("mid_rst_miso", {31'h0, s.spi_miso_o}, 32'h0);
    send_bits(32'hF0F0F000, 20, 1'b0);
    ss_high(1'b0);
    check("ignored_valid", {31'h0, s.rx_word_valid_o}, 32'h0);
    check("ignored_data", s.rx_data_o, 32'h0);
    push_rx(32'hDEADBEEF, 32);
    xfer(32'hDEADBEEF, 32, 1'b0);
    rx_check("after_rst");
    ack_rx();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
